// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit: sequential PC generator, single outstanding memory
// read, and a small FIFO of fetched (pc, instr) pairs that feeds IF/ID.
module instruction_fetch_queue #(
  parameter int                  PC_WIDTH    = 10,
  parameter int                  INSTR_WIDTH = 32,
  parameter int                  QDEPTH      = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     fetch_en,
  input  logic                     redirect_valid,
  input  logic [PC_WIDTH-1:0]      redirect_pc,
  output logic                     imem_req,
  output logic [PC_WIDTH-1:0]      imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INSTR_WIDTH-1:0]   out_instr,
  output logic [PC_WIDTH-1:0]      out_pc,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int AW = $clog2(QDEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(QDEPTH);

  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]    infl_pc_q, infl_pc_d;
  logic                   inflight_q, inflight_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic [INSTR_WIDTH-1:0] instr_mem [QDEPTH];
  logic [PC_WIDTH-1:0]    pc_mem    [QDEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;

  // Credits count the in-flight read as occupied, so a response always has a slot.
  assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign issue       = reset_n && fetch_en && !redirect_valid && (credit_used < DEPTH_C);
  assign push        = inflight_q && !redirect_valid;
  assign out_valid   = (count_q != '0) && !redirect_valid;
  assign pop         = out_valid && out_ready;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;
  assign q_count   = count_q;
  assign out_instr = (count_q != '0) ? instr_mem[rd_ptr_q] : '0;
  assign out_pc    = (count_q != '0) ? pc_mem[rd_ptr_q]    : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    inflight_d = 1'b0;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        infl_pc_d  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: entries are only visible while count_q says so.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= imem_rdata;
      pc_mem[wr_ptr_q]    <= infl_pc_q;
    end
  end

  a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
    !(push && (count_q == FULL_C)));

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all checked each cycle against a queue-based model.
module tb_instruction_fetch_queue;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [9:0]  out_pc;
  logic [2:0]  q_count;

  int checks   = 0;
  int failures = 0;

  instruction_fetch_queue dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .q_count        (q_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic go();
    @(posedge clock);
    #1;
  endtask

  // Memory: a request sampled in one cycle returns addr+0x100 in the next one;
  // otherwise the read bus carries garbage.
  initial begin
    logic       rq;
    logic [9:0] ra;
    imem_rdata = '0;
    forever begin
      @(negedge clock);
      rq = imem_req;
      ra = imem_addr;
      @(posedge clock);
      #1;
      imem_rdata = rq ? ({22'd0, ra} + 32'h100) : $urandom;
    end
  end

  // Reference model: a queue of fetched entries, one outstanding read, a PC.
  typedef struct {
    logic [9:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t       mq[$];
  logic [9:0] m_pc;
  bit         m_infl;
  logic [9:0] m_infl_pc;

  initial begin
    bit          e_req, e_valid;
    bit          s_rst, s_rv, s_ready;
    logic [9:0]  s_rpc;
    logic [31:0] s_rdata;
    mq.delete();
    m_pc   = 10'd0;
    m_infl = 1'b0;
    m_infl_pc = 10'd0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mq.delete();
        m_pc   = 10'd0;
        m_infl = 1'b0;
      end
      e_req   = reset_n && fetch_en && !redirect_valid && ((mq.size() + int'(m_infl)) < 4);
      e_valid = (mq.size() != 0) && !redirect_valid;
      chk("m_imem_req", {31'd0, imem_req}, {31'd0, e_req});
      chk("m_imem_addr", {22'd0, imem_addr}, {22'd0, m_pc});
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      chk("m_q_count", {29'd0, q_count}, mq.size());
      if (mq.size() != 0) begin
        chk("m_out_pc", {22'd0, out_pc}, {22'd0, mq[0].pc});
        chk("m_out_instr", out_instr, mq[0].instr);
      end else if (!reset_n) begin
        chk("m_rst_pc", {22'd0, out_pc}, 32'd0);
        chk("m_rst_instr", out_instr, 32'd0);
      end
      s_rst   = reset_n;
      s_rv    = redirect_valid;
      s_rpc   = redirect_pc;
      s_ready = out_ready;
      s_rdata = imem_rdata;
      @(posedge clock);
      if (s_rst && reset_n) begin
        if (s_rv) begin
          m_pc = s_rpc;
          mq.delete();
          m_infl = 1'b0;
        end else begin
          if (e_valid && s_ready) void'(mq.pop_front());
          if (m_infl) mq.push_back('{pc: m_infl_pc, instr: s_rdata});
          if (e_req) begin
            m_infl_pc = m_pc;
            m_infl    = 1'b1;
            m_pc      = m_pc + 10'd1;
          end else begin
            m_infl = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    fetch_en = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_count", {29'd0, q_count}, 32'd0);

    // Streaming from reset: one instruction per cycle starting two cycles in.
    go(); reset_n = 1'b1;
    @(negedge clock);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", {22'd0, imem_addr}, 32'd0);
    for (int k = 1; k < 8; k++) begin
      @(negedge clock);
      if (k >= 2) begin
        chk("stream_valid", {31'd0, out_valid}, 32'd1);
        chk("stream_pc", {22'd0, out_pc}, k - 2);
        chk("stream_instr", out_instr, 32'h100 + k - 2);
      end
    end

    // Consumer stalls 10 cycles: queue fills to 4 and fetch stops.
    go(); out_ready = 1'b0;
    repeat (9) go();
    @(negedge clock);
    chk("full_count", {29'd0, q_count}, 32'd4);
    chk("full_req", {31'd0, imem_req}, 32'd0);
    chk("full_head", {22'd0, out_pc}, 32'd6);
    go(); out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      chk("drain_pc", {22'd0, out_pc}, 6 + j);
    end

    // Redirect with three queued entries and a read in flight.
    go(); redirect_valid = 1'b1; redirect_pc = 10'h050;
    go(); redirect_valid = 1'b0;
    repeat (2) go();
    go(); out_ready = 1'b0;
    go();
    go(); redirect_valid = 1'b1; redirect_pc = 10'h200; out_ready = 1'b1;
    @(negedge clock);
    chk("redir_count_before", {29'd0, q_count}, 32'd3);
    chk("redir_valid_mask", {31'd0, out_valid}, 32'd0);
    chk("redir_no_req", {31'd0, imem_req}, 32'd0);
    go(); redirect_valid = 1'b0;
    @(negedge clock);
    chk("redir_t1_count", {29'd0, q_count}, 32'd0);
    chk("redir_t1_addr", {22'd0, imem_addr}, 32'h200);
    chk("redir_t1_req", {31'd0, imem_req}, 32'd1);
    go();
    @(negedge clock);
    chk("redir_t2_valid", {31'd0, out_valid}, 32'd0);
    go();
    @(negedge clock);
    chk("redir_t3_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_t3_pc", {22'd0, out_pc}, 32'h200);
    chk("redir_t3_instr", out_instr, 32'h300);

    // PC wrap at the top of the address space.
    go(); redirect_valid = 1'b1; redirect_pc = 10'h3FE;
    go(); redirect_valid = 1'b0;
    @(negedge clock);
    chk("wrap_addr0", {22'd0, imem_addr}, 32'h3FE);
    go();
    @(negedge clock);
    chk("wrap_addr1", {22'd0, imem_addr}, 32'h3FF);
    go();
    @(negedge clock);
    chk("wrap_addr2", {22'd0, imem_addr}, 32'h000);
    chk("wrap_req2", {31'd0, imem_req}, 32'd1);

    // fetch_en drop with a read in flight: response still lands, no new reads.
    repeat (3) go();
    go(); fetch_en = 1'b0;
    @(negedge clock);
    chk("fe_off_req", {31'd0, imem_req}, 32'd0);
    repeat (5) go();
    fetch_en = 1'b1;

    for (int i = 0; i < 1500; i++) begin
      go();
      fetch_en       = ($urandom_range(0, 9) < 8);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 10'($urandom_range(0, 1023));
    end

    // Mid-stream asynchronous reset, away from any clock edge.
    go(); redirect_valid = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    repeat (5) go();
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_req", {31'd0, imem_req}, 32'd0);
    chk("async_count", {29'd0, q_count}, 32'd0);
    chk("async_pc", {22'd0, out_pc}, 32'd0);
    repeat (2) go();
    reset_n = 1'b1;
    @(negedge clock);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", {22'd0, imem_addr}, 32'd0);
    repeat (3) go();
    @(negedge clock);
    chk("restart_pc", {22'd0, out_pc}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
